// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Used by instruction_fetch (optional perf counter: IFETCH_PERF_CNT_EN).
package ifetch_pkg;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_WAIT,
      ST_DRAIN
   } fetch_state_e;

   localparam logic [31:0] INST_WORD_BYTES  = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, pc+4} entries.
// Flush overrides push and pop; push when full and pop when empty are ignored.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push && (count_q != FULL_CNT);
      do_pop   = pop && (count_q != '0);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count gates every read of it.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, single-outstanding imem requests, buffered decoder handshake.
// Define IFETCH_PERF_CNT_EN to add the saturating stall_cycles output.
module instruction_fetch
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] instruction,
   output logic [31:0] opcplus4,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_addr_q, req_addr_d;
   logic [31:0]   pc_plus4;
   logic          fifo_push, fifo_pop, fifo_flush;
   logic [CW-1:0] fifo_count;
   logic [63:0]   fifo_head;

   assign pc_plus4 = fetch_pc_q + INST_WORD_BYTES;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      imem_req   = 1'b0;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      fifo_pop   = inst_valid && inst_ready;
      if (rst) begin
         fifo_pop = 1'b0;
      end else if (redirect) begin
         fifo_flush = 1'b1;
         fifo_pop   = 1'b0;
         fetch_pc_d = word_align(redirect_pc);
         unique case (state_q)
            ST_RUN:   state_d = ST_RUN;
            ST_WAIT:  state_d = imem_ack ? ST_RUN : ST_DRAIN;
            ST_DRAIN: state_d = imem_ack ? ST_RUN : ST_DRAIN;
            default:  state_d = ST_RUN;
         endcase
      end else begin
         unique case (state_q)
            ST_RUN: begin
               // Issuing only with a free slot reserves room for the eventual push.
               if (fifo_count < DEPTH_CNT) begin
                  imem_req   = 1'b1;
                  req_addr_d = fetch_pc_q;
                  state_d    = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_ack) begin
                  fifo_push  = 1'b1;
                  fetch_pc_d = pc_plus4;
                  state_d    = ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (imem_ack) begin
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
      end
   end

   // A stale request keeps its own address on the bus after a redirect moves the PC.
   assign imem_addr = (state_q == ST_RUN) ? fetch_pc_q : req_addr_q;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data ({imem_rdata, pc_plus4}),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   assign inst_valid  = (fifo_count != '0);
   assign instruction = inst_valid ? fifo_head[63:32] : '0;
   assign opcplus4    = inst_valid ? fifo_head[31:0] : '0;

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (inst_ready && !inst_valid && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random traffic
// against a queue-based reference model and a variable-latency memory model.
module tb_instruction_fetch;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] instruction;
   logic [31:0] opcplus4;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] stall_cycles;
`endif

   instruction_fetch #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .instruction (instruction),
      .opcplus4    (opcplus4),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: abstract fetch state.
   logic [31:0] m_pc;
   logic [31:0] m_req_addr;
   bit          m_inflight;
   bit          m_stale;
   logic [63:0] mbuf[$];
   logic [31:0] m_stall;

   // Memory model.
   bit          mem_busy;
   int          mem_wait;
   logic [31:0] mem_addr;
   int          mem_lat = 1;

   // Logs for directed checks.
   logic [31:0] req_log[$];
   logic [31:0] pop_log[$];
   int          cyc;
   int          first_req_cyc;
   int          first_val_cyc;
   logic        obs_req, obs_valid;
   logic [31:0] obs_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic clear_logs();
      req_log.delete();
      pop_log.delete();
   endtask

   // Called just after a falling edge; ends at the next falling edge.
   task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
      logic        exp_valid, exp_req;
      logic [31:0] exp_addr;
      logic [63:0] head;
      inst_ready  = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      imem_ack    = mem_busy && (mem_wait == 0);
      imem_rdata  = imem_ack ? mem_word(mem_addr) : $urandom;
      #1;
      exp_valid = (mbuf.size() != 0);
      head      = exp_valid ? mbuf[0] : 64'h0;
      exp_req   = !m_inflight && !redir && (mbuf.size() < DEPTH);
      exp_addr  = m_inflight ? m_req_addr : m_pc;
      check_eq("imem_req", imem_req, exp_req);
      check_eq("imem_addr", imem_addr, exp_addr);
      check_eq("inst_valid", inst_valid, exp_valid);
      check_eq("instruction", instruction, head[63:32]);
      check_eq("opcplus4", opcplus4, head[31:0]);
`ifdef IFETCH_PERF_CNT_EN
      check_eq("stall_cycles", stall_cycles, m_stall);
      if (rdy && !exp_valid && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
      obs_req   = imem_req;
      obs_addr  = imem_addr;
      obs_valid = inst_valid;
      if (imem_req) begin
         req_log.push_back(imem_addr);
         if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (inst_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (inst_valid && rdy && !redir) pop_log.push_back(opcplus4);

      if (redir) begin
         mbuf.delete();
         m_pc = {rpc[31:2], 2'b00};
         if (m_inflight) begin
            if (imem_ack) begin
               m_inflight = 0;
               m_stale    = 0;
            end else begin
               m_stale = 1;
            end
         end
      end else begin
         if (exp_valid && rdy) void'(mbuf.pop_front());
         if (m_inflight) begin
            if (imem_ack) begin
               if (!m_stale) begin
                  mbuf.push_back({imem_rdata, m_pc + 32'd4});
                  m_pc = m_pc + 32'd4;
               end
               m_inflight = 0;
               m_stale    = 0;
            end
         end else if (exp_req) begin
            m_inflight = 1;
            m_req_addr = m_pc;
         end
      end

      if (imem_ack) mem_busy = 0;
      else if (mem_busy) mem_wait--;
      if (imem_req) begin
         mem_busy = 1;
         mem_addr = imem_addr;
         mem_wait = mem_lat - 1;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst         = 1'b1;
      inst_ready  = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_ack    = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_req", imem_req, 1'b0);
      check_eq("rst_addr", imem_addr, 32'h0);
      check_eq("rst_valid", inst_valid, 1'b0);
      check_eq("rst_inst", instruction, 32'h0);
      check_eq("rst_pc4", opcplus4, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
      check_eq("rst_stall", stall_cycles, 32'h0);
`endif
      m_pc          = 32'h0;
      m_req_addr    = 32'h0;
      m_inflight    = 0;
      m_stale       = 0;
      m_stall       = 0;
      mbuf.delete();
      mem_busy      = 0;
      mem_wait      = 0;
      cyc           = 0;
      first_req_cyc = -1;
      first_val_cyc = -1;
      clear_logs();
      rst = 1'b0;
   endtask

   initial begin
      int n8;
      @(negedge clk);

      // Latency 1, decoder always ready.
      apply_reset();
      mem_lat = 1;
      repeat (8) step(1'b1, 1'b0, 32'h0);
      check_eq("t1_addr0", qget(req_log, 0), 32'h0);
      check_eq("t1_addr1", qget(req_log, 1), 32'h4);
      check_eq("t1_addr2", qget(req_log, 2), 32'h8);
      check_eq("t1_first_valid_gap", 64'(first_val_cyc - first_req_cyc), 64'd2);
      check_eq("t1_pc4_0", qget(pop_log, 0), 32'h4);
      check_eq("t1_pc4_1", qget(pop_log, 1), 32'h8);
      check_eq("t1_pc4_2", qget(pop_log, 2), 32'hC);

      // Decoder stalled: buffer fills, fetch stops, then resumes in order.
      apply_reset();
      mem_lat = 1;
      repeat (12) step(1'b0, 1'b0, 32'h0);
      check_eq("t2_nreq", 64'(req_log.size()), 64'd2);
      check_eq("t2_req_idle", obs_req, 1'b0);
      clear_logs();
      repeat (6) step(1'b1, 1'b0, 32'h0);
      check_eq("t2_pop0", qget(pop_log, 0), 32'h4);
      check_eq("t2_pop1", qget(pop_log, 1), 32'h8);
      check_eq("t2_resume", qget(req_log, 0), 32'h8);

      // Redirect while a request is in flight, latency 3.
      apply_reset();
      mem_lat = 3;
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      clear_logs();
      step(1'b1, 1'b1, 32'h0000_0100);
      step(1'b1, 1'b0, 32'h0);
      check_eq("t3_empty", obs_valid, 1'b0);
      repeat (12) step(1'b1, 1'b0, 32'h0);
      check_eq("t3_req", qget(req_log, 0), 32'h100);
      check_eq("t3_pc4", qget(pop_log, 0), 32'h104);

      // Redirect together with an ack and a pop.
      apply_reset();
      mem_lat = 1;
      repeat (3) step(1'b0, 1'b0, 32'h0);
      clear_logs();
      step(1'b1, 1'b1, 32'h0000_0200);
      step(1'b1, 1'b0, 32'h0);
      check_eq("t4_valid", obs_valid, 1'b0);
      check_eq("t4_req", obs_req, 1'b1);
      check_eq("t4_addr", obs_addr, 32'h200);
      repeat (6) step(1'b1, 1'b0, 32'h0);
      n8 = 0;
      foreach (pop_log[i]) if (pop_log[i] == 32'h8) n8++;
      check_eq("t4_dropped", 64'(n8), 64'd0);
      check_eq("t4_pc4", qget(pop_log, 0), 32'h204);

      // PC wrap; low redirect bits ignored.
      apply_reset();
      mem_lat = 1;
      step(1'b1, 1'b1, 32'hFFFF_FFFF);
      repeat (8) step(1'b1, 1'b0, 32'h0);
      check_eq("t5_req0", qget(req_log, 0), 32'hFFFF_FFFC);
      check_eq("t5_req1", qget(req_log, 1), 32'h0);
      check_eq("t5_pc4", qget(pop_log, 0), 32'h0);

`ifdef IFETCH_PERF_CNT_EN
      apply_reset();
      mem_lat = 20;
      repeat (5) step(1'b1, 1'b0, 32'h0);
      #1;
      check_eq("perf_stall5", stall_cycles, 32'd5);
      apply_reset();
`endif

      // Random traffic with a mid-run reset.
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rpc;
         if (i == 1500) apply_reset();
         mem_lat = $urandom_range(1, 4);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
         step($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, rpc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
